// File: rtl/branch_ex.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_ex: branch/jump execute stage; resolves target, writes link, redirects
// fetch via valid/ack and holds a flush window. Rev 1.0
// ----------------------------------------------------------------------------
module branch_ex #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_nop_in,
  input  logic        is_jmp_in,
  input  logic        is_imm_type_in,
  input  logic        zero_ext_in,
  input  logic [1:0]  op_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  rd_in,
  input  logic [21:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        redirect_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] C_FLUSH = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rpc_q, rpc_d;
  logic          wb_en_q, wb_en_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic [31:0] w_ext;
  logic [31:0] w_off;
  logic [31:0] w_cmp_b;
  logic [31:0] w_target;
  logic        w_cond;
  logic        w_taken;
  logic        w_accept;
  logic        w_unused;

  assign w_ext    = zero_ext_in ? {10'b0, imm_in} : {{10{imm_in[21]}}, imm_in};
  assign w_off    = {w_ext[29:0], 2'b00};
  assign w_cmp_b  = is_imm_type_in ? w_ext : rs2_val;
  assign w_accept = (state_q == S_IDLE) && !stall && !is_nop_in;
  assign w_taken  = is_jmp_in | w_cond;
  // Register-indirect jumps are word-aligned by clearing the low two bits.
  assign w_target = (is_jmp_in && !is_imm_type_in) ? ((rs1_val + w_ext) & ~32'h3)
                                                   : (pc_in + w_off);
  assign w_unused = ^{rs1_in, rs2_in, w_ext[31:30]};

  always_comb begin
    w_cond = 1'b0;
    case (op_in)
      2'b00:   w_cond = (rs1_val == w_cmp_b);
      2'b01:   w_cond = (rs1_val != w_cmp_b);
      2'b10:   w_cond = ($signed(rs1_val) <  $signed(w_cmp_b));
      default: w_cond = ($signed(rs1_val) >= $signed(w_cmp_b));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rpc_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpc_q     <= rpc_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpc_d     = rpc_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;

    if (w_accept && is_jmp_in && (rd_in != 5'd0)) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = rd_in;
      wb_data_d = pc_in + 32'd4;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept && w_taken) begin
          state_d = S_REDIRECT;
          rpc_d   = w_target;
        end
      end
      S_REDIRECT: begin
        if (redirect_ack) begin
          if (FLUSH_CYCLES != 0) begin
            state_d = S_FLUSH;
            cnt_d   = C_FLUSH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign redirect_valid = (state_q == S_REDIRECT);
  assign flush          = (state_q != S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign redirect_pc    = rpc_q;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule
`default_nettype wire
